// File: rtl/bit_serial_adder.sv
// bit_serial_adder: WIDTH-bit adder that reuses one full-adder cell, one bit per clock, LSB first.
// It latches the operands on start, runs WIDTH cycles, then presents a registered sum with a done pulse.

module full_adder_modular (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh, r_b_sh, r_s_sh, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c_q, r_carry_out, r_busy, r_done;
    logic             w_fa_s, w_fa_c;
    logic [WIDTH-1:0] w_s_next;

    full_adder_modular u_fa (
        .i_a(r_a_sh[0]),
        .i_b(r_b_sh[0]),
        .i_c(r_c_q),
        .o_s(w_fa_s),
        .o_c(w_fa_c)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at index 0.
    assign w_s_next = WIDTH'({w_fa_s, r_s_sh} >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_s_sh      <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_c_q       <= 1'b0;
            r_carry_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a_sh  <= a;
                    r_b_sh  <= b;
                    r_c_q   <= carry_in;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_s_sh <= w_s_next;
                    r_c_q  <= w_fa_c;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_sum       <= w_s_next;
                        r_carry_out <= w_fa_c;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;
    assign carry_out = r_carry_out;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: table vectors and corner sequences on WIDTH=8, exhaustive sweeps on WIDTH=1 and 2.
// Expected results queue up at start and are popped when done rises.
module tb_bit_serial_adder;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       co;
    } vec_t;

    typedef struct {
        logic [8:0] res;
        int         cyc;
    } exp_t;

    localparam int NV = 8;

    logic       clk, rst;
    logic       start8, cin8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, co1;
    logic [0:0] a1, b1, sum1;
    logic       start2, cin2, busy2, done2, co2;
    logic [1:0] a2, b2, sum2;

    int   checks, failures, cyc;
    exp_t q8[$], q1[$], q2[$];
    vec_t vecs[NV];

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
    );

    bit_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(rst), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1)
    );

    bit_serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(rst), .start(start2), .a(a2), .b(b2), .carry_in(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) chk("done8_unexpected", 1, 0);
            else begin
                e = q8.pop_front();
                chk("res8", {co8, sum8}, e.res);
                chk("lat8", cyc, e.cyc);
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("done1_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                chk("res1", {co1, sum1}, e.res);
                chk("lat1", cyc, e.cyc);
            end
        end
        if (done2) begin
            if (q2.size() == 0) chk("done2_unexpected", 1, 0);
            else begin
                e = q2.pop_front();
                chk("res2", {co2, sum2}, e.res);
                chk("lat2", cyc, e.cyc);
            end
        end
    endtask

    // One clock: cyc names the most recent rising edge; outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mon();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy8 | busy1 | busy2) && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(busy8 | busy1 | busy2), 0);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1;
        {start8, cin8, a8, b8} = '0;
        {start1, cin1, a1, b1} = '0;
        {start2, cin2, a2, b2} = '0;
        vecs[0] = '{8'h00, 8'h01, 1'b0, 8'h01, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

        @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_co", co8, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            a8 = vecs[i].a; b8 = vecs[i].b; cin8 = vecs[i].cin; start8 = 1'b1;
            q8.push_back('{{vecs[i].co, vecs[i].sum}, cyc + 1 + 8});
            tick();
            start8 = 1'b0;
            chk("busy8_accept", busy8, 1);
            chk("done8_accept", done8, 0);
            wait_idle();
        end

        // start pulses and operand changes during RUN must be ignored; outputs hold
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{9'h04B, cyc + 1 + 8});
        tick();
        a8 = 8'h55; b8 = 8'h55; start8 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            start8 = (i >= 1 && i <= 4);
            tick();
            if (i < 7) begin
                chk("hold_sum8", sum8, vecs[NV-1].sum);
                chk("hold_co8", co8, vecs[NV-1].co);
            end
        end
        start8 = 1'b0;
        wait_idle();

        // start held high: second add is accepted on the first IDLE edge
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{9'h003, cyc + 1 + 8});
        tick();
        a8 = 8'h10; b8 = 8'h20;
        q8.push_back('{9'h030, cyc + 18});
        for (int i = 0; i < 10; i++) tick();
        start8 = 1'b0;
        chk("busy8_b2b", busy8, 1);
        wait_idle();

        // async reset mid-run aborts without a done pulse
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_co", co8, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("abort_sum_held", sum8, 0);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        q8.push_back('{9'h047, cyc + 1 + 8});
        tick();
        start8 = 1'b0;
        wait_idle();

        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++) begin
                    a1 = 1'(a); b1 = 1'(b); cin1 = 1'(c); start1 = 1'b1;
                    q1.push_back('{9'(a + b + c), cyc + 1 + 1});
                    tick();
                    start1 = 1'b0;
                    chk("busy1_accept", busy1, 1);
                    wait_idle();
                end

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c); start2 = 1'b1;
                    q2.push_back('{9'(a + b + c), cyc + 1 + 2});
                    tick();
                    start2 = 1'b0;
                    chk("busy2_accept", busy2, 1);
                    wait_idle();
                end

        tick();
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
